dti_tbu_mux: RTL and testbench

- Upstream neighbour of the DTI partial-reset adapter. Merges TBU_NUM per-TBU DTI AXI-Stream request ports into the single req_t* stream that the adapter consumes, tagging each packet with its port index as tid.
- Routes the adapter's single rsp_t* stream back to per-TBU response ports by rsp_tid.
- Request path: packet-atomic round-robin arbitration. Both paths use registered outputs.

---
 rtl/dti_tbu_mux_pkg.sv | 12 +
 rtl/dti_tbu_mux_if.sv | 59 +++++
 rtl/dti_rr_arb.sv | 46 ++++
 rtl/dti_tbu_mux.sv | 94 +++++++++
 tb/tb_dti_tbu_mux.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dti_tbu_mux_pkg.sv
// Shared widths and arbiter state for the DTI TBU request/response mux.
package dti_tbu_mux_pkg;
    localparam int DTI_DATA_W = 80;
    localparam int DTI_KEEP_W = 10;
    localparam int DTI_TID_W  = 6;

    typedef enum logic {ARB = 1'b0, LOCK = 1'b1} arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/dti_tbu_mux_if.sv
// Per-TBU request/response streams plus the merged adapter-side streams.
interface dti_tbu_mux_if import dti_tbu_mux_pkg::*; #(
    parameter int TBU_NUM = 4,
    parameter int DATA_W  = DTI_DATA_W,
    parameter int KEEP_W  = DTI_KEEP_W,
    parameter int TID_W   = DTI_TID_W
);
    logic [TBU_NUM-1:0]             s_req_tvalid;
    logic [TBU_NUM-1:0][DATA_W-1:0] s_req_tdata;
    logic [TBU_NUM-1:0][KEEP_W-1:0] s_req_tkeep;
    logic [TBU_NUM-1:0]             s_req_tlast;
    logic [TBU_NUM-1:0]             s_req_tready;

    logic              m_req_tvalid;
    logic [DATA_W-1:0] m_req_tdata;
    logic [KEEP_W-1:0] m_req_tkeep;
    logic              m_req_tlast;
    logic [TID_W-1:0]  m_req_tid;
    logic              m_req_tready;

    logic              s_rsp_tvalid;
    logic [DATA_W-1:0] s_rsp_tdata;
    logic [KEEP_W-1:0] s_rsp_tkeep;
    logic              s_rsp_tlast;
    logic [TID_W-1:0]  s_rsp_tid;
    logic              s_rsp_tready;

    logic [TBU_NUM-1:0] m_rsp_tvalid;
    logic [DATA_W-1:0]  m_rsp_tdata;
    logic [KEEP_W-1:0]  m_rsp_tkeep;
    logic               m_rsp_tlast;
    logic [TBU_NUM-1:0] m_rsp_tready;

    logic err_bad_tid;

    modport slave (
        input  s_req_tvalid, s_req_tdata, s_req_tkeep, s_req_tlast,
        output s_req_tready,
        output m_req_tvalid, m_req_tdata, m_req_tkeep, m_req_tlast, m_req_tid,
        input  m_req_tready,
        input  s_rsp_tvalid, s_rsp_tdata, s_rsp_tkeep, s_rsp_tlast, s_rsp_tid,
        output s_rsp_tready,
        output m_rsp_tvalid, m_rsp_tdata, m_rsp_tkeep, m_rsp_tlast,
        input  m_rsp_tready,
        output err_bad_tid
    );

    modport master (
        output s_req_tvalid, s_req_tdata, s_req_tkeep, s_req_tlast,
        input  s_req_tready,
        input  m_req_tvalid, m_req_tdata, m_req_tkeep, m_req_tlast, m_req_tid,
        output m_req_tready,
        output s_rsp_tvalid, s_rsp_tdata, s_rsp_tkeep, s_rsp_tlast, s_rsp_tid,
        input  s_rsp_tready,
        input  m_rsp_tvalid, m_rsp_tdata, m_rsp_tkeep, m_rsp_tlast,
        output m_rsp_tready,
        input  err_bad_tid
    );
endinterface

// File: rtl/dti_rr_arb.sv
// Packet-atomic round-robin grant: searches from ptr+1 in ARB, holds ptr in LOCK.
module dti_rr_arb import dti_tbu_mux_pkg::*; #(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          acc,
    input  logic          acc_last,
    output logic          gnt_vld,
    output logic [IW-1:0] gnt_idx
);
    arb_state_e    state;
    logic [IW-1:0] ptr;

    // In LOCK the grant is ptr itself, since ptr was set to the locked port.
    always_comb begin
        int c;
        c       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (state == LOCK) begin
            gnt_vld = 1'b1;
            gnt_idx = ptr;
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (int'(ptr) + k) % N;
                if (!gnt_vld && req[IW'(c)]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = IW'(c);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
            ptr   <= IW'(N - 1);
        end else if (acc) begin
            ptr   <= gnt_idx;
            state <= acc_last ? ARB : LOCK;
        end
    end
endmodule

// File: rtl/dti_tbu_mux.sv
// Merges per-TBU DTI request streams into one tid-tagged stream and routes responses back by tid.
module dti_tbu_mux import dti_tbu_mux_pkg::*; #(
    parameter int TBU_NUM = 4,
    parameter int DATA_W  = DTI_DATA_W,
    parameter int KEEP_W  = DTI_KEEP_W,
    parameter int TID_W   = DTI_TID_W
) (
    input logic         clk,
    input logic         rst_n,
    dti_tbu_mux_if.slave bus
);
    localparam int IW = idx_w(TBU_NUM);

    logic          gnt_vld;
    logic [IW-1:0] gnt_idx;
    logic          can_load;
    logic          req_acc;

    assign can_load = !bus.m_req_tvalid || bus.m_req_tready;
    assign req_acc  = gnt_vld && can_load && bus.s_req_tvalid[gnt_idx];

    dti_rr_arb #(.N(TBU_NUM), .IW(IW)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (bus.s_req_tvalid),
        .acc      (req_acc),
        .acc_last (bus.s_req_tlast[gnt_idx]),
        .gnt_vld  (gnt_vld),
        .gnt_idx  (gnt_idx)
    );

    always_comb begin
        bus.s_req_tready = '0;
        if (gnt_vld && can_load) bus.s_req_tready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.m_req_tvalid <= 1'b0;
            bus.m_req_tdata  <= '0;
            bus.m_req_tkeep  <= '0;
            bus.m_req_tlast  <= 1'b0;
            bus.m_req_tid    <= '0;
        end else if (req_acc) begin
            bus.m_req_tvalid <= 1'b1;
            bus.m_req_tdata  <= bus.s_req_tdata[gnt_idx];
            bus.m_req_tkeep  <= bus.s_req_tkeep[gnt_idx];
            bus.m_req_tlast  <= bus.s_req_tlast[gnt_idx];
            bus.m_req_tid    <= TID_W'(gnt_idx);
        end else if (bus.m_req_tready) begin
            bus.m_req_tvalid <= 1'b0;
        end
    end

    // Response side: one register shared by all ports, so a stalled port blocks the stream.
    logic          rsp_vld;
    logic [IW-1:0] rsp_tid;
    logic [31:0]   tid_ext;
    logic          tid_ok;
    logic          rsp_acc;

    assign tid_ext          = 32'(bus.s_rsp_tid);
    assign tid_ok           = tid_ext < 32'(TBU_NUM);
    assign bus.s_rsp_tready = !rsp_vld || bus.m_rsp_tready[rsp_tid];
    assign rsp_acc          = bus.s_rsp_tvalid && bus.s_rsp_tready;

    always_comb begin
        bus.m_rsp_tvalid = '0;
        if (rsp_vld) bus.m_rsp_tvalid[rsp_tid] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld         <= 1'b0;
            rsp_tid         <= '0;
            bus.m_rsp_tdata <= '0;
            bus.m_rsp_tkeep <= '0;
            bus.m_rsp_tlast <= 1'b0;
            bus.err_bad_tid <= 1'b0;
        end else begin
            if (rsp_acc && tid_ok) begin
                rsp_vld         <= 1'b1;
                rsp_tid         <= IW'(bus.s_rsp_tid);
                bus.m_rsp_tdata <= bus.s_rsp_tdata;
                bus.m_rsp_tkeep <= bus.s_rsp_tkeep;
                bus.m_rsp_tlast <= bus.s_rsp_tlast;
            end else if (rsp_vld && bus.m_rsp_tready[rsp_tid]) begin
                rsp_vld <= 1'b0;
            end
            // Out-of-range tids are consumed and dropped; the flag stays up until reset.
            if (rsp_acc && !tid_ok) bus.err_bad_tid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dti_tbu_mux.sv
// Directed bench for dti_tbu_mux: per-cycle behavioural model plus hand-computed beat logs.
module tb_dti_tbu_mux;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dti_tbu_mux_if #(.TBU_NUM(N), .DATA_W(80), .KEEP_W(10), .TID_W(6)) bus ();

    dti_tbu_mux #(.TBU_NUM(N), .DATA_W(80), .KEEP_W(10), .TID_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { logic [79:0] d; logic l; int gap; } beat_t;
    typedef struct { logic [5:0] t; logic [79:0] d; logic l; } rbeat_t;
    typedef struct { int t; logic [79:0] d; logic l; int cyc; } log_t;

    beat_t  rq [N][$];
    rbeat_t rspq[$];
    log_t   qlog[$];
    log_t   rlog[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [N-1:0] req_acc = '0;
    logic         rsp_acc = 1'b0;
    int gap_left[N];
    bit gap_ld[N];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model state: owner port (-1 = free), last granted port, output and response registers.
    int          m_own, m_last;
    logic        o_v, o_l, r_v, r_l, m_err;
    logic [79:0] o_d, r_d;
    logic [9:0]  o_k, r_k;
    int          o_t, r_t;

    always @(negedge clk) begin
        int g;
        logic can, exp_srdy;
        logic [N-1:0] exp_rdy, exp_mv;
        cyc++;
        if (!rst_n) begin
            m_own = -1; m_last = N - 1; m_err = 1'b0;
            o_v = 1'b0; o_d = '0; o_k = '0; o_l = 1'b0; o_t = 0;
            r_v = 1'b0; r_d = '0; r_k = '0; r_l = 1'b0; r_t = 0;
        end
        can = !o_v || bus.m_req_tready;
        g = m_own;
        if (g < 0)
            for (int k = 1; k <= N; k++)
                if (g < 0 && bus.s_req_tvalid[(m_last + k) % N]) g = (m_last + k) % N;
        exp_rdy = (g >= 0 && can) ? N'(1 << g) : '0;
        chk("s_req_tready", bus.s_req_tready, exp_rdy);
        chk("m_req_tvalid", bus.m_req_tvalid, o_v);
        if (o_v) begin
            chk("m_req_tdata", bus.m_req_tdata, o_d);
            chk("m_req_tkeep", bus.m_req_tkeep, o_k);
            chk("m_req_tlast", bus.m_req_tlast, o_l);
            chk("m_req_tid",   bus.m_req_tid,   o_t);
        end
        exp_srdy = !r_v || bus.m_rsp_tready[r_t];
        exp_mv   = r_v ? N'(1 << r_t) : '0;
        chk("s_rsp_tready", bus.s_rsp_tready, exp_srdy);
        chk("m_rsp_tvalid", bus.m_rsp_tvalid, exp_mv);
        chk("err_bad_tid",  bus.err_bad_tid,  m_err);
        if (r_v) begin
            chk("m_rsp_tdata", bus.m_rsp_tdata, r_d);
            chk("m_rsp_tkeep", bus.m_rsp_tkeep, r_k);
            chk("m_rsp_tlast", bus.m_rsp_tlast, r_l);
        end

        if (rst_n && bus.m_req_tvalid && bus.m_req_tready)
            qlog.push_back('{int'(bus.m_req_tid), bus.m_req_tdata, bus.m_req_tlast, cyc});
        for (int i = 0; i < N; i++)
            if (rst_n && bus.m_rsp_tvalid[i] && bus.m_rsp_tready[i])
                rlog.push_back('{i, bus.m_rsp_tdata, bus.m_rsp_tlast, cyc});
        req_acc = bus.s_req_tvalid & bus.s_req_tready;
        rsp_acc = bus.s_rsp_tvalid && bus.s_rsp_tready;

        if (rst_n) begin
            if (g >= 0 && can && bus.s_req_tvalid[g]) begin
                o_v = 1'b1; o_d = bus.s_req_tdata[g]; o_k = bus.s_req_tkeep[g];
                o_l = bus.s_req_tlast[g]; o_t = g; m_last = g;
                m_own = bus.s_req_tlast[g] ? -1 : g;
            end else if (bus.m_req_tready) o_v = 1'b0;
            if (bus.s_rsp_tvalid && exp_srdy && int'(bus.s_rsp_tid) < N) begin
                r_v = 1'b1; r_t = int'(bus.s_rsp_tid); r_d = bus.s_rsp_tdata;
                r_k = bus.s_rsp_tkeep; r_l = bus.s_rsp_tlast;
            end else if (r_v && bus.m_rsp_tready[r_t]) r_v = 1'b0;
            if (bus.s_rsp_tvalid && exp_srdy && int'(bus.s_rsp_tid) >= N) m_err = 1'b1;
        end
    end

    // Source drivers: pop on acceptance seen at the previous negedge, then present the next head.
    initial begin
        bus.s_req_tvalid = '0; bus.s_req_tdata = '0; bus.s_req_tkeep = '0; bus.s_req_tlast = '0;
        bus.s_rsp_tvalid = 1'b0; bus.s_rsp_tdata = '0; bus.s_rsp_tkeep = '0;
        bus.s_rsp_tlast = 1'b0; bus.s_rsp_tid = '0;
        for (int i = 0; i < N; i++) begin gap_left[i] = 0; gap_ld[i] = 1'b0; end
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (!rst_n) begin rq[i].delete(); gap_ld[i] = 1'b0; end
                else if (req_acc[i] && rq[i].size() > 0) begin void'(rq[i].pop_front()); gap_ld[i] = 1'b0; end
                bus.s_req_tvalid[i] = 1'b0;
                if (rq[i].size() > 0) begin
                    if (!gap_ld[i]) begin gap_left[i] = rq[i][0].gap; gap_ld[i] = 1'b1; end
                    if (gap_left[i] > 0) gap_left[i]--;
                    else begin
                        bus.s_req_tvalid[i] = 1'b1;
                        bus.s_req_tdata[i]  = rq[i][0].d;
                        bus.s_req_tkeep[i]  = rq[i][0].d[9:0];
                        bus.s_req_tlast[i]  = rq[i][0].l;
                    end
                end
            end
            if (!rst_n) rspq.delete();
            else if (rsp_acc && rspq.size() > 0) void'(rspq.pop_front());
            bus.s_rsp_tvalid = rspq.size() > 0;
            if (rspq.size() > 0) begin
                bus.s_rsp_tid   = rspq[0].t;
                bus.s_rsp_tdata = rspq[0].d;
                bus.s_rsp_tkeep = rspq[0].d[9:0];
                bus.s_rsp_tlast = rspq[0].l;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic push(input int p, input int beats, input logic [79:0] base, input int gap1);
        for (int b = 0; b < beats; b++)
            rq[p].push_back('{base + 80'(b), (b == beats - 1), (b == 1) ? gap1 : 0});
    endtask

    task automatic push_rsp(input logic [5:0] t, input logic [79:0] d);
        rspq.push_back('{t, d, 1'b1});
    endtask

    function automatic bit busy();
        bit b;
        b = bus.m_req_tvalid || (bus.m_rsp_tvalid != '0) || rspq.size() > 0;
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_idle(input string nm, input int limit);
        int c;
        c = 0;
        while (busy() && c < limit) begin step(1); c++; end
        chk({nm, "_drain_timeout"}, (c >= limit), 1'b0);
    endtask

    task automatic chk_q(input int k, input int t, input logic [79:0] d, input logic l);
        if (k < qlog.size()) begin
            chk("qlog_tid",  qlog[k].t, t);
            chk("qlog_data", qlog[k].d, d);
            chk("qlog_last", qlog[k].l, l);
        end else chk("qlog_missing_beat", qlog.size(), k + 1);
    endtask

    task automatic chk_r(input int k, input int t, input logic [79:0] d);
        if (k < rlog.size()) begin
            chk("rlog_tid",  rlog[k].t, t);
            chk("rlog_data", rlog[k].d, d);
        end else chk("rlog_missing_beat", rlog.size(), k + 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; step(2); rst_n = 1'b1; step(1);
    endtask

    initial begin
        bus.m_req_tready = 1'b1;
        bus.m_rsp_tready = '1;
        step(3);
        chk("rst_m_req_tvalid", bus.m_req_tvalid, 1'b0);
        chk("rst_m_rsp_tvalid", bus.m_rsp_tvalid, 4'h0);
        chk("rst_err_bad_tid",  bus.err_bad_tid,  1'b0);
        rst_n = 1'b1; step(1);

        // Two 3-beat packets: port 0 wins first, no interleave, contiguous output.
        qlog.delete();
        push(0, 3, 80'h000, 0); push(2, 3, 80'h200, 0);
        wait_idle("t1", 50);
        chk("t1_count", qlog.size(), 6);
        chk_q(0, 0, 80'h000, 0); chk_q(1, 0, 80'h001, 0); chk_q(2, 0, 80'h002, 1);
        chk_q(3, 2, 80'h200, 0); chk_q(4, 2, 80'h201, 0); chk_q(5, 2, 80'h202, 1);
        if (qlog.size() == 6) chk("t1_contiguous", qlog[5].cyc - qlog[0].cyc, 5);

        // All ports, single-beat packets: tid 0,1,2,3 repeating, one beat per cycle.
        do_reset();
        qlog.delete();
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < N; p++) push(p, 1, 80'(p * 256 + r), 0);
        wait_idle("t2", 60);
        chk("t2_count", qlog.size(), 12);
        for (int k = 0; k < 12; k++) chk_q(k, k % 4, 80'((k % 4) * 256 + k / 4), 1'b1);
        if (qlog.size() == 12) chk("t2_every_cycle", qlog[11].cyc - qlog[0].cyc, 11);

        // Port 1 locked with a 5-cycle tvalid gap; port 3 waits for port 1's tlast.
        qlog.delete();
        push(1, 3, 80'h100, 5); push(3, 1, 80'h300, 0);
        wait_idle("t3", 60);
        chk("t3_count", qlog.size(), 4);
        chk_q(0, 1, 80'h100, 0); chk_q(1, 1, 80'h101, 0); chk_q(2, 1, 80'h102, 1);
        chk_q(3, 3, 80'h300, 1);
        if (qlog.size() == 4) begin
            chk("t3_gap", qlog[1].cyc - qlog[0].cyc, 6);
            chk("t3_port3_after_tlast", qlog[3].cyc - qlog[2].cyc, 1);
        end

        // Downstream stall: output held, s_req_tready low, no loss or duplication.
        qlog.delete();
        bus.m_req_tready = 1'b0;
        push(2, 3, 80'h200, 0);
        step(3);
        chk("t4_hold_valid", bus.m_req_tvalid, 1'b1);
        chk("t4_hold_data",  bus.m_req_tdata, 80'h200);
        chk("t4_hold_tid",   bus.m_req_tid, 6'd2);
        chk("t4_hold_ready", bus.s_req_tready, 4'h0);
        step(2);
        chk("t4_still_data", bus.m_req_tdata, 80'h200);
        bus.m_req_tready = 1'b1;
        wait_idle("t4", 40);
        chk("t4_count", qlog.size(), 3);
        chk_q(0, 2, 80'h200, 0); chk_q(1, 2, 80'h201, 0); chk_q(2, 2, 80'h202, 1);

        // Response routing with port 1 blocked: stream stalls, order preserved.
        rlog.delete();
        bus.m_rsp_tready = 4'b1101;
        push_rsp(6'd2, 80'h2A); push_rsp(6'd1, 80'h1B); push_rsp(6'd2, 80'h2C);
        step(3);
        chk("t5_stall_valid", bus.m_rsp_tvalid, 4'b0010);
        chk("t5_stall_ready", bus.s_rsp_tready, 1'b0);
        step(2);
        chk("t5_still_stalled", bus.m_rsp_tvalid, 4'b0010);
        bus.m_rsp_tready = '1;
        wait_idle("t5", 40);
        chk("t5_count", rlog.size(), 3);
        chk_r(0, 2, 80'h2A); chk_r(1, 1, 80'h1B); chk_r(2, 2, 80'h2C);

        // Bad tid: consumed, nothing routed, sticky error; then reset during LOCK.
        push_rsp(6'd7, 80'h7F);
        wait_idle("t6", 20);
        step(1);
        chk("t6_err_set", bus.err_bad_tid, 1'b1);
        chk("t6_no_route", rlog.size(), 3);
        push(0, 3, 80'h000, 8);
        step(4);
        chk("t6_err_sticky", bus.err_bad_tid, 1'b1);
        rst_n = 1'b0;
        step(2);
        chk("t6_rst_m_req_tvalid", bus.m_req_tvalid, 1'b0);
        chk("t6_rst_s_req_tready", bus.s_req_tready, 4'h0);
        chk("t6_rst_m_rsp_tvalid", bus.m_rsp_tvalid, 4'h0);
        chk("t6_rst_err",          bus.err_bad_tid,  1'b0);
        rst_n = 1'b1; step(1);
        qlog.delete();
        push(1, 1, 80'h111, 0); push(0, 1, 80'h011, 0);
        wait_idle("t6b", 30);
        chk("t6b_count", qlog.size(), 2);
        chk_q(0, 0, 80'h011, 1); chk_q(1, 1, 80'h111, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, got cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
